// File: rtl/decoder_onehot_pkg.sv
// Shared types and decode helper for the one-hot decoder pipe.
// onehot_of works on a fixed maximum width; callers slice down to their NUM_BITS.
package decoder_onehot_pkg;

    localparam int unsigned MAX_BITS = 64;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_t;

    function automatic logic [MAX_BITS-1:0] onehot_of(input int unsigned index,
                                                      input int unsigned num_bits);
        logic [MAX_BITS-1:0] vec;
        vec = '0;
        if (index < num_bits) begin
            vec = {{(MAX_BITS-1){1'b0}}, 1'b1} << index;
        end
        return vec;
    endfunction

endpackage

// File: rtl/decoder_onehot_pipe.sv
// Binary index -> one-hot vector through a 2-entry skid buffer; 1-cycle latency, 1 entry/cycle.
// o__ready depends only on occupancy and reset; out-of-range indices are consumed, flagged and counted.
module decoder_onehot_pipe
    import decoder_onehot_pkg::*;
#(
    parameter int unsigned NUM_BITS     = 11,
    parameter int unsigned LOG_NUM_BITS = $clog2(NUM_BITS),
    parameter int unsigned ERR_CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i__valid,
    input  logic [LOG_NUM_BITS-1:0] i__index,
    output logic                    o__ready,
    output logic                    o__valid,
    output logic [NUM_BITS-1:0]     o__onehot,
    input  logic                    i__ready,
    output logic                    o__range_err,
    output logic [ERR_CNT_W-1:0]    o__err_count
);

    occ_t                state;
    occ_t                state_nxt;
    logic [NUM_BITS-1:0] head;
    logic [NUM_BITS-1:0] head_nxt;
    logic [NUM_BITS-1:0] skid;
    logic [NUM_BITS-1:0] skid_nxt;
    logic [NUM_BITS-1:0] entry;
    logic [MAX_BITS-1:0] dec_full;
    logic                in_range;
    logic                accept;
    logic                accept_ok;
    logic                drain;
    int unsigned         idx;

    assign o__ready  = !reset && (state != ST_FULL);
    assign o__valid  = (state != ST_EMPTY);
    assign o__onehot = head;

    assign accept    = i__valid && o__ready;
    assign accept_ok = accept && in_range;
    assign drain     = o__valid && i__ready;

    // Compare at 32 bits so a power-of-two NUM_BITS still elaborates cleanly.
    always_comb begin
        idx      = 32'(i__index);
        in_range = (idx < NUM_BITS);
        dec_full = onehot_of(idx, NUM_BITS);
        entry    = dec_full[NUM_BITS-1:0];
    end

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        skid_nxt  = skid;
        case (state)
            ST_EMPTY: begin
                if (accept_ok) begin
                    head_nxt  = entry;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept_ok && drain) begin
                    head_nxt = entry;
                end else if (accept_ok) begin
                    skid_nxt  = entry;
                    state_nxt = ST_FULL;
                end else if (drain) begin
                    head_nxt  = '0;
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    head_nxt  = skid;
                    skid_nxt  = '0;
                    state_nxt = ST_ONE;
                end
            end
            default: begin
                head_nxt  = '0;
                skid_nxt  = '0;
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_EMPTY;
            head         <= '0;
            skid         <= '0;
            o__range_err <= 1'b0;
            o__err_count <= '0;
        end else begin
            state        <= state_nxt;
            head         <= head_nxt;
            skid         <= skid_nxt;
            o__range_err <= accept && !in_range;
            if (accept && !in_range && (o__err_count != '1)) begin
                o__err_count <= o__err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// Scoreboard bench: a queue model predicts occupancy, output order and error counting every cycle.
module tb_decoder_onehot_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        i__valid;
    logic [3:0]  i__index;
    logic        o__ready;
    logic        o__valid;
    logic [10:0] o__onehot;
    logic        i__ready;
    logic        o__range_err;
    logic [7:0]  o__err_count;

    logic        i8_valid;
    logic [2:0]  i8_index;
    logic        o8_ready;
    logic        o8_valid;
    logic [7:0]  o8_onehot;
    logic        o8_range_err;
    logic [7:0]  o8_err_count;

    int total = 0;
    int bad   = 0;

    logic [10:0] exp_q[$];
    logic        exp_rerr = 1'b0;
    int          exp_ecnt = 0;
    bit          chk_en   = 1'b0;

    always #5 clk = ~clk;

    decoder_onehot_pipe #(.NUM_BITS(11), .LOG_NUM_BITS(4), .ERR_CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .i__valid     (i__valid),
        .i__index     (i__index),
        .o__ready     (o__ready),
        .o__valid     (o__valid),
        .o__onehot    (o__onehot),
        .i__ready     (i__ready),
        .o__range_err (o__range_err),
        .o__err_count (o__err_count)
    );

    decoder_onehot_pipe #(.NUM_BITS(8), .LOG_NUM_BITS(3), .ERR_CNT_W(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .i__valid     (i8_valid),
        .i__index     (i8_index),
        .o__ready     (o8_ready),
        .o__valid     (o8_valid),
        .o__onehot    (o8_onehot),
        .i__ready     (1'b1),
        .o__range_err (o8_range_err),
        .o__err_count (o8_err_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Hold i__valid until the DUT takes the index; returns at posedge+1.
    task automatic send(input logic [3:0] idx);
        bit done;
        done     = 1'b0;
        i__valid = 1'b1;
        i__index = idx;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (o__ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        i__valid = 1'b0;
        chk("send_accept", 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Check the present outputs, then advance the model by this cycle's handshakes.
    always @(negedge clk) begin
        logic [10:0] head_exp;
        bit          acc;
        bit          drn;
        if (chk_en) begin
            head_exp = (exp_q.size() > 0) ? exp_q[0] : 11'd0;
            chk("ready",     32'(o__ready),     32'(!reset && exp_q.size() < 2));
            chk("valid",     32'(o__valid),     32'(exp_q.size() > 0));
            chk("onehot",    32'(o__onehot),    32'(head_exp));
            chk("range_err", 32'(o__range_err), 32'(exp_rerr));
            chk("err_count", 32'(o__err_count), 32'(exp_ecnt));
        end
        if (reset) begin
            exp_q.delete();
            exp_rerr = 1'b0;
            exp_ecnt = 0;
            chk_en   = 1'b1;
        end else if (chk_en) begin
            acc      = i__valid && (exp_q.size() < 2);
            drn      = (exp_q.size() > 0) && i__ready;
            exp_rerr = 1'b0;
            if (drn) void'(exp_q.pop_front());
            if (acc) begin
                if (int'(i__index) < 11) begin
                    exp_q.push_back(11'd1 << i__index);
                end else begin
                    exp_rerr = 1'b1;
                    if (exp_ecnt != 255) exp_ecnt++;
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        i__valid = 1'b0;
        i__index = 4'd0;
        i__ready = 1'b1;
        i8_valid = 1'b0;
        i8_index = 3'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // single pulse
        send(4'd3);
        idle(3);

        // full-rate stream
        for (int k = 0; k < 11; k++) send(4'(k));
        idle(3);

        // backpressure: 5 and 6 fill the buffer, 7 waits for the first drain
        i__ready = 1'b0;
        send(4'd5);
        send(4'd6);
        fork
            send(4'd7);
            begin
                repeat (3) @(posedge clk);
                #1 i__ready = 1'b1;
            end
        join
        idle(4);

        // out-of-range indices, then saturation
        send(4'd12);
        send(4'd15);
        idle(3);
        for (int k = 0; k < 300; k++) send((k % 2 == 0) ? 4'd13 : 4'd14);
        idle(3);

        // reset while FULL
        i__ready = 1'b0;
        send(4'd1);
        send(4'd2);
        reset = 1'b1;
        idle(1);
        reset    = 1'b0;
        i__ready = 1'b1;
        idle(3);
        send(4'd9);
        idle(3);

        // power-of-two instance: indices 0..7 back to back
        for (int k = 0; k <= 8; k++) begin
            i8_valid = (k < 8);
            i8_index = 3'(k);
            @(negedge clk);
            if (k > 0) begin
                chk("d8_valid",  32'(o8_valid),  32'd1);
                chk("d8_onehot", 32'(o8_onehot), 32'(8'd1 << (k - 1)));
            end
            chk("d8_range_err", 32'(o8_range_err), 32'd0);
            @(posedge clk);
            #1;
        end
        i8_valid = 1'b0;
        idle(2);
        chk("d8_idle_valid", 32'(o8_valid),     32'd0);
        chk("d8_err_count",  32'(o8_err_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_onehot_pipe.md
# decoder_onehot_pipe

Registered binary-to-one-hot decoder with valid/ready flow control on both sides, the decode counterpart of `encoder_onehot`. It accepts a binary select index per handshake, range-checks it, and presents the one-hot vector from a 2-entry skid buffer. It sits between configuration/route-select logic and one-hot-selected crossbar or mux enables in the PE datapath. Out-of-range indices are dropped and counted.

## Interface
- `NUM_BITS`, 11: width of the one-hot output; legal indices are 0..NUM_BITS-1.
- `LOG_NUM_BITS`, $clog2(NUM_BITS): index width.
- `ERR_CNT_W`, 8: width of the saturating error counter.

- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `i__valid`  input  1: upstream index valid.
- `i__index`  input  LOG_NUM_BITS: binary index to decode.
- `o__ready`  output  1: block can accept an index this cycle.
- `o__valid`  output  1: `o__onehot` holds a valid decoded vector.
- `o__onehot`  output  NUM_BITS: decoded vector, exactly one bit set when `o__valid`.
- `i__ready`  input  1: downstream accepts `o__onehot` this cycle.
- `o__range_err`  output  1: one-cycle pulse, an out-of-range index was accepted.
- `o__err_count`  output  ERR_CNT_W: saturating count of out-of-range indices.

## Operation
- Accept = `i__valid && o__ready`; drain = `o__valid && i__ready`.
- Occupancy state: EMPTY (0 entries), ONE (head register valid), FULL (head + skid valid).
- `o__ready` = 0 while `reset` is high; otherwise 1 in EMPTY/ONE, 0 in FULL. It is a function of state and `reset` only, with no combinational path from `i__valid` or `i__ready`.
- In-range accept (`i__index < NUM_BITS`): the entry stores `1 << i__index`.
- Out-of-range accept: the index is consumed but no entry is created. `o__range_err` = 1 on the next cycle and `o__err_count` increments, saturating at 2^ERR_CNT_W-1.
- When NUM_BITS is a power of two, out-of-range cannot occur; the range logic must still elaborate.
- Transitions:
  - EMPTY: in-range accept -> ONE.
  - ONE:
    - accept without drain -> FULL (new entry to skid).
    - drain without accept -> EMPTY.
    - accept and drain together -> ONE, and the head is replaced by the new entry.
  - FULL: drain -> ONE (skid moves to head); no accept is possible.
  - An out-of-range accept counts as no accept for occupancy purposes.
- `o__valid` = state != EMPTY; `o__onehot` = head register.
- When `o__valid` = 0, `o__onehot` is all zeros; X is never driven.
- While `o__valid && !i__ready`, `o__onehot` holds stable.
- Order is strictly FIFO.

## Timing
- Reset values, held the cycle after `reset` is sampled high:
  - state EMPTY, `o__valid` 0, `o__onehot` 0.
  - `o__ready` 0 during reset, 1 on the first cycle after `reset` deasserts.
  - `o__range_err` 0, `o__err_count` 0.
- Reset mid-operation discards all buffered entries and clears the counter, with no drain.
- Latency: accept in cycle N gives `o__valid` in cycle N+1 if the buffer was empty or drained.
- Throughput: 1 entry per cycle when `i__ready` is held high.
- `o__range_err` asserts in cycle N+1 after an out-of-range accept in cycle N, for exactly 1 cycle per offending accept. Back-to-back errors keep it high.

## Structure
- Package `decoder_onehot_pkg`: occupancy state enum (EMPTY, ONE, FULL) and a function `onehot_of(index, NUM_BITS)` returning the decoded vector, or zeros when out of range.
- No sub-modules; a single always_ff for head, skid, state and counter, plus a small always_comb for next-state logic.

## Test plan
- Reset then `i__index`=3 with `i__valid` pulsed 1 cycle and `i__ready`=1 -> next cycle `o__valid`=1, `o__onehot`=11'h008; the cycle after, `o__valid`=0 and `o__onehot`=0.
- Stream indices 0..10 with `i__ready`=1 -> `o__onehot` = 1<<k on consecutive cycles, `o__ready` never drops.
- `i__ready`=0, offer 5, 6, 7 -> 5 and 6 accepted, `o__ready`=0 with 7 pending. Raise `i__ready` -> output 11'h020, 11'h040, 11'h080 in order, and 7 is accepted on the cycle after the first drain.
- `i__index`=12 and 15 accepted -> `o__range_err` high 2 cycles, `o__err_count`=2, `o__valid` stays 0. Drive 300 errors -> count saturates at 255.
- Assert `reset` in FULL state -> next cycle `o__valid`=0, `o__onehot`=0, `o__err_count`=0; `o__ready` returns to 1 the cycle after `reset` falls.
- NUM_BITS=8 build: indices 0..7 -> correct one-hot output, `o__range_err` never asserts.
